// File: rtl/inta_sequencer_pkg.sv
// Shared types and helpers for the 8259A-style INTA sequencer.
// Holds the sequencer state set, default bus constants and the acknowledge byte formatter.
package inta_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1,
        ST_G1,
        ST_P2,
        ST_G2,
        ST_P3
    } state_t;

    localparam logic [7:0] CALL_OPCODE_DEF    = 8'hCD;
    localparam logic [2:0] SPURIOUS_LEVEL_DEF = 3'd7;

    // Byte driven during INTA pulse pulse_idx (1..3); 0 when nothing is driven.
    function automatic logic [7:0] format_vector(
        input logic       mode,
        input logic       adi,
        input logic [2:0] icw1_addr,
        input logic [7:0] icw2,
        input logic [2:0] level,
        input logic [1:0] pulse_idx
    );
        logic [7:0] v;
        v = 8'h00;
        case (pulse_idx)
            2'd1: v = mode ? 8'h00 : CALL_OPCODE_DEF;
            2'd2: begin
                if (mode)
                    v = {icw2[7:3], level};
                else if (adi)
                    v = {icw1_addr, level, 2'b00};
                else
                    v = {icw1_addr[2:1], level, 3'b000};
            end
            2'd3:    v = icw2;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/inta_sequencer_edge.sv
// INTA edge detector: one-cycle fall and rise pulses from the synchronous inta_n.
// The register idles high so a low inta_n at reset release reads as a fresh fall.
module inta_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic inta_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            inta_q <= 1'b1;
        else
            inta_q <= inta_n;
    end

    assign fall = inta_q & ~inta_n;
    assign rise = ~inta_q & inta_n;

endmodule

// File: rtl/inta_sequencer.sv
// INTA sequencer: raises INT, follows the 2/3-pulse acknowledge train, freezes the
// winning level at the first pulse, drives vector/CALL bytes and strobes ISR set/AEOI.
module inta_sequencer
    import inta_sequencer_pkg::*;
#(
    parameter logic [7:0] CALL_OPCODE    = CALL_OPCODE_DEF,
    parameter logic [2:0] SPURIOUS_LEVEL = SPURIOUS_LEVEL_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_pending,
    input  logic [2:0] highest_priority,
    input  logic       inta_n,
    input  logic       mode_8086,
    input  logic       aeoi,
    input  logic       adi,
    input  logic [2:0] icw1_addr,
    input  logic [7:0] icw2,
    output logic       int_out,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       isr_set,
    output logic [2:0] isr_index,
    output logic       auto_eoi,
    output logic       busy
);

    state_t     state, state_nxt;
    logic       fall, rise;
    logic       mode_l;
    logic [2:0] level_l;
    logic       spur_l;

    logic       capture;
    logic       seq_end;
    logic       mode_eff;
    logic [1:0] pulse_nxt;
    logic       oe_nxt;
    logic [7:0] data_nxt;
    logic       int_nxt;

    inta_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .inta_n (inta_n),
        .fall   (fall),
        .rise   (rise)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        seq_end   = 1'b0;
        case (state)
            ST_IDLE: if (fall) begin
                state_nxt = ST_P1;
                capture   = 1'b1;
            end
            ST_P1: if (rise) state_nxt = ST_G1;
            ST_G1: if (fall) state_nxt = ST_P2;
            ST_P2: if (rise) begin
                if (mode_l) begin
                    state_nxt = ST_IDLE;
                    seq_end   = 1'b1;
                end else begin
                    state_nxt = ST_G2;
                end
            end
            ST_G2: if (fall) state_nxt = ST_P3;
            ST_P3: if (rise) begin
                state_nxt = ST_IDLE;
                seq_end   = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // The first pulse byte is formed before mode_l is loaded, so use the live pin then.
        mode_eff = capture ? mode_8086 : mode_l;

        case (state_nxt)
            ST_P1:   pulse_nxt = 2'd1;
            ST_P2:   pulse_nxt = 2'd2;
            ST_P3:   pulse_nxt = 2'd3;
            default: pulse_nxt = 2'd0;
        endcase

        oe_nxt = (pulse_nxt == 2'd2) || (pulse_nxt == 2'd3) ||
                 ((pulse_nxt == 2'd1) && !mode_eff);

        if (!oe_nxt)
            data_nxt = 8'h00;
        else if (pulse_nxt == 2'd1)
            data_nxt = CALL_OPCODE;
        else
            data_nxt = format_vector(mode_eff, adi, icw1_addr, icw2, level_l, pulse_nxt);

        int_nxt = (state == ST_IDLE) && !fall && int_pending;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_l   <= 1'b1;
            level_l  <= 3'd0;
            spur_l   <= 1'b0;
            int_out  <= 1'b0;
            data_out <= 8'h00;
            data_oe  <= 1'b0;
            isr_set  <= 1'b0;
            auto_eoi <= 1'b0;
        end else begin
            if (capture) begin
                mode_l  <= mode_8086;
                level_l <= int_pending ? highest_priority : SPURIOUS_LEVEL;
                spur_l  <= ~int_pending;
            end
            int_out  <= int_nxt;
            data_out <= data_nxt;
            data_oe  <= oe_nxt;
            isr_set  <= capture & int_pending;
            auto_eoi <= seq_end & aeoi & ~spur_l;
        end
    end

    assign isr_index = level_l;
    assign busy      = (state != ST_IDLE);

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Downstream stage of the priority resolver in the 8259A-compatible interrupt controller.
- Raises INT toward the CPU and tracks the INTA pulse train: two pulses in 8086 mode, three in 8080 mode.
- Freezes the winning IR level at the first INTA, commands the ISR bit set, and drives the vector or CALL bytes onto the data bus.
- Issues the automatic-EOI strobe at the end of the sequence when AEOI is enabled.

Parameters:
- CALL_OPCODE, 8'hCD, byte driven on the first INTA pulse in 8080 mode.
- SPURIOUS_LEVEL, 3'd7, level reported when INTA arrives with no request pending.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- int_pending  input  1  resolver has an unmasked request above current ISR priority.
- highest_priority  input  3  winning IR level from the resolver.
- inta_n  input  1  CPU acknowledge, active low, already synchronous to clk.
- mode_8086  input  1  ICW4 uPM: 1 = 8086/88, 0 = 8080/85.
- aeoi  input  1  ICW4 automatic EOI enable.
- adi  input  1  ICW1 address interval: 1 = 4-byte spacing, 0 = 8-byte spacing.
- icw1_addr  input  3  ICW1 A7..A5 (8080 low address byte).
- icw2  input  8  ICW2: T7..T3 in 8086 mode, A15..A8 in 8080 mode.
- int_out  output  1  INT pin to the CPU.
- data_out  output  8  byte driven during the acknowledge.
- data_oe  output  1  data bus drive enable.
- isr_set  output  1  one-cycle strobe to set ISR[isr_index].
- isr_index  output  3  frozen IR level.
- auto_eoi  output  1  one-cycle strobe to clear ISR[isr_index].
- busy  output  1  acknowledge sequence in progress.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; all outputs 0.
  - inta_q=1, captured level=0, latched mode=1.
- Edge detection:
  - inta_q <= inta_n each cycle.
  - fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
- States: IDLE, P1, G1, P2, G2, P3. P = pulse low, G = gap between pulses.
- IDLE:
  - int_out = int_pending, registered, so it follows with 1-cycle latency.
  - On fall:
    - Latch mode_8086 into mode_l.
    - If int_pending: capture highest_priority and pulse isr_set in the next cycle.
    - Otherwise capture SPURIOUS_LEVEL, with no isr_set (spurious IR7).
    - int_out <= 0; go to P1.
- P1:
  - 8086: data_oe=0.
  - 8080: data_out=CALL_OPCODE, data_oe=1.
  - On rise, go to G1.
- G1: data_oe=0; on fall, go to P2.
- P2 data:
  - 8086: data_out={icw2[7:3], level}.
  - 8080, adi=1: data_out={icw1_addr, level, 2'b00}.
  - 8080, adi=0: data_out={icw1_addr[2:1], level, 3'b000}.
  - data_oe=1.
- P2 on rise:
  - 8086: sequence end, go to IDLE.
  - 8080: go to G2.
- G2: data_oe=0; on fall, go to P3.
- P3: data_out=icw2, data_oe=1; on rise, sequence end, go to IDLE.
- Sequence end:
  - auto_eoi pulses for one cycle when aeoi=1 and the level was not spurious.
  - data_oe drops in the same cycle as the rise detection.
  - int_out is re-evaluated from the cycle after returning to IDLE.
- Data output timing:
  - data_out/data_oe are registered.
  - They become valid 1 cycle after the fall and return to 0 one cycle after the rise.
  - data_out=0 whenever data_oe=0.
- busy = (state != IDLE).
- Isolation during a sequence:
  - Changes on highest_priority, int_pending, mode_8086, icw1_addr, icw2 or adi after the first fall do not alter isr_index.
  - They do not alter the latched mode.
  - ICW fields are sampled live in each pulse.
- A fall and a rise in the same cycle are impossible, because inta_n is single-bit.
- A missing pulse waits indefinitely; there is no timeout.
- Reset mid-sequence aborts immediately: no auto_eoi, and the bus is released.

Decomposition:
- Shared package contents:
  - State enum.
  - CALL_OPCODE and SPURIOUS_LEVEL defaults.
  - Function format_vector(mode, adi, icw1_addr, icw2, level, pulse_idx) returning 8 bits.
- One sub-module, inta_edge_detect: inta_n register plus the fall/rise pulses; reset value 1.

Test Plan:
- 8086 mode, icw2=8'h40, int_pending=1, level=5, two INTA pulses:
  - int_out falls after the first fall.
  - isr_set=1 with isr_index=5 once.
  - data_oe=0 in P1; data_out=8'h45 in P2.
  - auto_eoi=0 when aeoi=0.
- 8080 mode, adi=1, icw1_addr=3'b101, icw2=8'h12, level=3, three pulses:
  - Bus bytes are 8'hCD, 8'hAC, 8'h12.
  - With aeoi=1, auto_eoi pulses once after the third rise with isr_index=3.
- 8080 mode, adi=0, icw1_addr=3'b110, level=6: second byte is 8'hF0.
- Spurious: int_pending=0 at the first fall (8086, icw2=8'h08):
  - No isr_set.
  - data_out=8'h0F in P2.
  - No auto_eoi even with aeoi=1.
- Freeze check: level changes from 2 to 0 and mode_8086 toggles between P1 and P2:
  - isr_index stays 2.
  - The latched mode is kept.
- Reset asserted during G1:
  - All outputs 0 and state IDLE immediately.
  - After release with int_pending=1, int_out=1 one cycle later.
